// File: rtl/mem_wb_pkg.sv
// Shared encodings for the MEM/WB stage: writeback source select,
// FSM state codes and the default writeback register reset value.
package mem_wb_pkg;

    // inMulSel encodings (3 is treated like ALU)
    localparam logic [1:0] MUL_ALU = 2'd0;
    localparam logic [1:0] MUL_MEM = 2'd1;
    localparam logic [1:0] MUL_PC  = 2'd2;

    // Memory handshake FSM
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_WAIT = 1'b1;

    localparam logic [31:0] RESET_VALUE_DEFAULT = 32'd0;

endpackage

// File: rtl/mem_timeout_counter.sv
// Saturating 8-bit wait-cycle timer; expire flags count == LIMIT.
module mem_timeout_counter #(
    parameter logic [7:0] LIMIT = 8'd255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] count,
    output logic       expire
);

    logic [7:0] count_q, count_d;

    // Clear has priority; otherwise count up and stick at 0xFF
    always_comb begin
        count_d = count_q;
        if (clear)
            count_d = 8'd0;
        else if (enable && count_q != 8'hFF)
            count_d = count_q + 8'd1;
    end

    // Timer register
    always_ff @(posedge clk) begin
        if (reset)
            count_q <= 8'd0;
        else
            count_q <= count_d;
    end

    assign count  = count_q;
    assign expire = (count_q == LIMIT);

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline stage: drives the data-memory handshake, stalls
// upstream while a memory op is outstanding, aborts after a timeout and
// registers the writeback index/enable/data.
module mem_wb_stage
    import mem_wb_pkg::*;
#(
    parameter logic [31:0] RESET_VALUE = RESET_VALUE_DEFAULT,
    parameter logic [7:0]  MEM_TIMEOUT = 8'd255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  inWrtIndex,
    input  logic        inRegWrEn,
    input  logic [1:0]  inMulSel,
    input  logic [31:0] inAluOut,
    input  logic [31:0] inData2Out,
    input  logic [31:0] inPC,
    input  logic        inIsLoad,
    input  logic        inIsStore,
    output logic        memReq,
    output logic        memWe,
    output logic [31:0] memAddr,
    output logic [31:0] memWData,
    input  logic        memAck,
    input  logic [31:0] memRData,
    output logic        memStall,
    output logic        memErr,
    output logic [3:0]  outWrtIndex,
    output logic        outRegWrEn,
    output logic [31:0] outWrtData
);

    logic        state_q, state_d;
    logic        mem_err_q, mem_err_d;
    logic [3:0]  wb_idx_q, wb_idx_d;
    logic        wb_en_q, wb_en_d;
    logic [31:0] wb_data_q, wb_data_d;

    logic       mem_op, in_wait, req, ack, abort, stall;
    logic       tmr_clear, tmr_en, tmr_expire;
    logic [7:0] tmr_cnt_unused;  // kept on a named net for debug visibility

    mem_timeout_counter #(.LIMIT(MEM_TIMEOUT)) u_tmr (
        .clk    (clk),
        .reset  (reset),
        .clear  (tmr_clear),
        .enable (tmr_en),
        .count  (tmr_cnt_unused),
        .expire (tmr_expire)
    );

    // Handshake, stall, FSM next state and timer control
    always_comb begin
        mem_op    = inIsLoad | inIsStore;
        in_wait   = (state_q == ST_WAIT);
        // Reset forces the request low so an in-flight access is dropped
        req       = ~reset & (in_wait | mem_op);
        ack       = memAck & req;
        abort     = in_wait & ~ack & tmr_expire;
        stall     = ~reset & ((~in_wait & mem_op & ~ack) | (in_wait & ~ack & ~abort));
        tmr_clear = ~in_wait & mem_op & ~ack;
        tmr_en    = in_wait;
        state_d   = state_q;
        if (!in_wait && mem_op && !ack)
            state_d = ST_WAIT;
        else if (in_wait && (ack || abort))
            state_d = ST_IDLE;
        mem_err_d = mem_err_q | abort;
    end

    // Writeback register next value; bubble while stalled
    always_comb begin
        wb_idx_d  = wb_idx_q;
        wb_en_d   = 1'b0;
        wb_data_d = wb_data_q;
        if (!stall) begin
            wb_idx_d = inWrtIndex;
            // Load+store together is a store: never writes the register file
            wb_en_d  = inRegWrEn & ~abort & ~(inIsLoad & inIsStore);
            case (inMulSel)
                MUL_MEM: wb_data_d = memRData;
                MUL_PC:  wb_data_d = inPC;
                default: wb_data_d = inAluOut;
            endcase
        end
    end

    // State, sticky error and writeback registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            mem_err_q <= 1'b0;
            wb_idx_q  <= RESET_VALUE[3:0];
            wb_en_q   <= RESET_VALUE[0];
            wb_data_q <= RESET_VALUE;
        end else begin
            state_q   <= state_d;
            mem_err_q <= mem_err_d;
            wb_idx_q  <= wb_idx_d;
            wb_en_q   <= wb_en_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign memReq      = req;
    assign memWe       = req & inIsStore;
    assign memAddr     = req ? inAluOut : 32'd0;
    assign memWData    = req ? inData2Out : 32'd0;
    assign memStall    = stall;
    assign memErr      = mem_err_q;
    assign outWrtIndex = wb_idx_q;
    assign outRegWrEn  = wb_en_q;
    assign outWrtData  = wb_data_q;

endmodule
